// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the multicycle RV32 control path: sequencer states,
// opcode constants, ALUop codes, mux-select encodings and fault codes. The
// datapath and ALU_Control import the same package so select values agree.
// ----------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_HALT
   } state_t;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   // ALUop codes consumed by ALU_Control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B select
   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   typedef enum logic [1:0] {
      FAULT_NONE    = 2'b00,
      FAULT_ILLEGAL = 2'b01,
      FAULT_TIMEOUT = 2'b10
   } fault_t;

   // Only beq (000) and bne (001) are implemented.
   function automatic logic is_supported_branch(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001);
   endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// ----------------------------------------------------------------------------
// ctrl_watchdog
// Counts consecutive cycles a memory request waits without mem_ready and
// pulses timeout on the cycle the count reaches TIMEOUT_CYC.
// TIMEOUT_CYC = 0 disables the watchdog (timeout never asserts).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      request pending and not accepted this cycle
//   clear       no pending wait (request accepted or absent)
//   timeout     combinational pulse: this is wait cycle number TIMEOUT_CYC
// ----------------------------------------------------------------------------
module ctrl_watchdog #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic timeout
);

   localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   // Count value held during the final allowed wait cycle.
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam bit ACTIVE = (TIMEOUT_CYC != 0);

   logic [CW-1:0] count;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && ACTIVE)
         count <= count + CW'(1);
   end

   assign timeout = ACTIVE && enable && (count == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
// Main sequencer of the multicycle RV32 core. Steps each instruction from
// FETCH through writeback, drives the datapath selects, write enables, the
// ALUop code and a valid/ready memory handshake. Counts retired instructions
// and halts (sticky until reset) on an illegal opcode or memory timeout.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode, funct3    instruction fields from IR
//   zero              ALU zero flag, current cycle
//   mem_ready         memory accepts/completes the request this cycle
//   mem_req, mem_we   request valid / request is a write
//   adr_src           memory address: 0 PC, 1 ALUOut
//   ir_write          load IR and oldPC
//   pc_write          load PC from result bus
//   reg_write         register-file write enable
//   alu_src_a/b       ALU operand selects
//   alu_op            ALUop code for ALU_Control
//   result_src        result bus select
//   retired           instructions completed since reset (wraps)
//   halted            high in HALT
//   fault             00 none, 01 illegal, 10 memory timeout
// ----------------------------------------------------------------------------
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic [1:0]       fault
);

   state_t           state, state_nxt;
   fault_t           fault_q, fault_nxt;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   logic             wd_timeout;

   // mem_req is decoded from state only, so the watchdog inputs form no
   // combinational loop through mem_ready.
   ctrl_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (mem_req & ~mem_ready),
      .clear  (~mem_req | mem_ready),
      .timeout(wd_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         fault_q   <= FAULT_NONE;
         retired_q <= '0;
      end else begin
         state   <= state_nxt;
         fault_q <= fault_nxt;
         if (retire)
            retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave a signal unassigned and infer a latch.
      state_nxt  = state;
      fault_nxt  = fault_q;
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_REGB;
      alu_op     = ALUOP_ADD;
      result_src = RES_ALUOUT;
      halted     = 1'b0;

      case (state)
         S_IDLE: state_nxt = S_FETCH;

         S_FETCH: begin
            // PC+4 is computed while the instruction is fetched and written
            // back to PC on the accepting cycle.
            mem_req    = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALURESULT;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (wd_timeout) begin
               state_nxt = S_HALT;
               fault_nxt = FAULT_TIMEOUT;
            end
         end

         S_DECODE: begin
            // Speculative branch target oldPC+imm lands in ALUOut.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
            case (opcode)
               OPC_LOAD, OPC_STORE: state_nxt = S_MEMADR;
               OPC_RTYPE:           state_nxt = S_EXEC_R;
               OPC_ITYPE:           state_nxt = S_EXEC_I;
               OPC_JAL:             state_nxt = S_JAL;
               OPC_LUI:             state_nxt = S_LUI;
               OPC_BRANCH: begin
                  if (is_supported_branch(funct3)) begin
                     state_nxt = S_BRANCH;
                  end else begin
                     state_nxt = S_HALT;
                     fault_nxt = FAULT_ILLEGAL;
                  end
               end
               default: begin
                  state_nxt = S_HALT;
                  fault_nxt = FAULT_ILLEGAL;
               end
            endcase
         end

         S_MEMADR: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
            state_nxt = (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               state_nxt = S_MEMWB;
            end else if (wd_timeout) begin
               state_nxt = S_HALT;
               fault_nxt = FAULT_TIMEOUT;
            end
         end

         S_MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end else if (wd_timeout) begin
               state_nxt = S_HALT;
               fault_nxt = FAULT_TIMEOUT;
            end
         end

         S_EXEC_R: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_REGB;
            alu_op    = ALUOP_RTYPE;
            state_nxt = S_ALUWB;
         end

         S_EXEC_I: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ITYPE;
            state_nxt = S_ALUWB;
         end

         S_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
            state_nxt = S_ALUWB;
         end

         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_BRANCH: begin
            // Compare regA-regB; ALUOut still holds the target from DECODE.
            // funct3[0] inverts the sense: beq takes on zero, bne on !zero.
            alu_src_a  = SRCA_REGA;
            alu_src_b  = SRCB_REGB;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            pc_write   = zero ^ funct3[0];
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_JAL: begin
            // PC <- target (ALUOut); ALU computes link oldPC+4 for ALUWB.
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            state_nxt  = S_ALUWB;
         end

         S_HALT: halted = 1'b1;

         default: state_nxt = S_IDLE;
      endcase
   end

   assign retired = retired_q;
   assign fault   = fault_q;

endmodule
